axis_video_out_framer: RTL and testbench
========================================

Name: axis_video_out_framer

Overview:
- Output stage directly downstream of the bicubic value buffer.
- Consumes its 24-bit upscaled pixel stream and the EOL/EOF sideband, and re-times it through a registered 2-entry skid buffer.
- Emits a standard AXI4-Stream video interface (tuser = start of frame, tlast = end of line) to the video DMA/display sink.
- Adds frame-boundary enable/disable control and a frame counter.

Parameters:
- PIXEL_WIDTH, 24, width of an RGB pixel {B,G,R}, 8 bits each.
- H_ACTIVE, 1280, output pixels per line; used only by the geometry checker.
- V_ACTIVE, 720, output lines per frame; used only by the geometry checker.
- FCNT_WIDTH, 16, width of the frame counter.

Ports:
- i_clk  input  1  clock.
- i_rstn  input  1  asynchronous active-low reset.
- i_enable  input  1  run request; sampled only at frame boundaries.
- s_axis_tdata  input  PIXEL_WIDTH  pixel from the value buffer.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted.
- i_eol  input  1  sideband of the current beat: last pixel of a line.
- i_eof  input  1  sideband of the current beat: last pixel of a frame; always coincides with i_eol.
- m_axis_tdata  output  PIXEL_WIDTH  output pixel.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  sink ready.
- m_axis_tlast  output  1  end of line.
- m_axis_tuser  output  1  start of frame, on the first pixel of a frame.
- o_busy  output  1  high when state is not S_IDLE.
- o_frame_cnt  output  FCNT_WIDTH  number of completed frames, wraps.
- i_err_clr  input  1  clears the sticky error flags.
- o_err_line  output  1  sticky line-length error.
- o_err_frame  output  1  sticky frame-length error.

Behaviour:
- Clocking and reset:
  - Single clock domain: i_clk. Reset is asynchronous and active-low on i_rstn.
  - All flops clear on reset.
  - Reset values: s_axis_tready=0, m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, o_busy=0, o_frame_cnt=0, o_err_*=0, state=S_IDLE, sof_pending=1.
- Beat definitions:
  - An input beat is accepted when s_axis_tvalid && s_axis_tready. i_eol and i_eof are qualified by the accept.
  - An output beat completes when m_axis_tvalid && m_axis_tready.
- Pipeline:
  - Output register plus one skid register, each holding {tdata, eol, eof, sof}.
  - Latency: 1 cycle from input accept to m_axis_tvalid when the output register is empty.
  - Full throughput: 1 beat/cycle under continuous tready.
  - s_axis_tready is registered: it is high when the skid entry is empty and the state is S_ACTIVE or S_DRAIN.
  - m_axis_tvalid never drops and tdata/tlast/tuser never change while m_axis_tvalid && !m_axis_tready.
  - The skid register absorbs the single beat accepted in the cycle tready falls. The skid is unloaded into the output register first; no beat is dropped or reordered.
- Sideband mapping:
  - m_axis_tlast = stored eol.
  - m_axis_tuser = stored sof.
  - sof is taken from sof_pending at input accept. sof_pending clears on any accepted beat and sets on an accepted beat with i_eof.
- State machine:
  - S_IDLE: s_axis_tready=0. Goes to S_ACTIVE when i_enable=1 and sof_pending=1.
  - S_ACTIVE: passes beats. If i_enable=0, goes to S_DRAIN. If an EOF beat is accepted in the same cycle that i_enable=0, goes directly to S_IDLE.
  - S_DRAIN: passes beats until an EOF beat is accepted, then goes to S_IDLE. If i_enable returns to 1, goes back to S_ACTIVE.
  - Frames are never truncated; disable takes effect only after a complete frame.
  - The output pipeline keeps draining in S_IDLE. o_busy stays high until the pipeline is empty.
- Frame counter: o_frame_cnt increments when an output beat with eof completes (not at input), modulo 2^FCNT_WIDTH.
- Simultaneous events: accept and output-complete in the same cycle with the skid empty pass straight through; occupancy is unchanged.
- Reset mid-frame: the pipeline is flushed with no output beat. After reset the next accepted beat carries tuser=1.

Optional Feature:
- Macro: VIDEO_FRAMER_GEOM_CHECK_EN.
- When defined:
  - Pixel counter x (0..H_ACTIVE-1) and line counter y (0..V_ACTIVE-1) are advanced on input accept.
  - o_err_line sets if i_eol is seen with x!=H_ACTIVE-1, or if x==H_ACTIVE-1 without i_eol.
  - o_err_frame sets if i_eof is seen with y!=V_ACTIVE-1, or if EOL at y==V_ACTIVE-1 arrives without i_eof.
  - Counters resynchronise on i_eol (x=0) and i_eof (y=0).
  - Flags are sticky and clear on i_err_clr. If a set and a clear occur in the same cycle, set wins.
- When not defined: no counters; o_err_line and o_err_frame are tied 0; i_err_clr is ignored.

Test Plan:
- Reset, i_enable=1, stream a 4x2 frame (H_ACTIVE=4, V_ACTIVE=2) with m_axis_tready=1. Expect 8 beats, 1-cycle latency, tuser on beat 0 only, tlast on beats 3 and 7, o_frame_cnt=1.
- Same frame with m_axis_tready toggling 1,0,0,1 repeatedly. Expect identical data order, no loss, and outputs stable while stalled; the skid is used exactly when tready falls.
- Drop i_enable at beat 2 of frame 1. Expect frame 1 to complete (all 8 beats), s_axis_tready=0 afterwards, state S_IDLE, o_busy=0 once drained. Re-enable: next beat has tuser=1.
- Assert i_rstn low mid-frame (beat 5). Expect outputs cleared immediately (async). After release and enable, the first beat has tuser=1 and o_frame_cnt=0.
- Geometry check (macro defined): inject EOL at x=2 with H_ACTIVE=4. Expect o_err_line=1, held until i_err_clr. EOF at y=0 sets o_err_frame. With the macro undefined, both flags stay 0.
- Counter wrap: FCNT_WIDTH=2, run 5 frames. Expect o_frame_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/axis_video_out_framer.sv
// AXI4-Stream video output framer: 2-entry skid re-timing, frame-boundary enable and frame counter.
// Optional geometry checker enabled by defining VIDEO_FRAMER_GEOM_CHECK_EN.
module axis_video_out_framer #(
  parameter int PIXEL_WIDTH = 24,
  parameter int H_ACTIVE    = 1280,
  parameter int V_ACTIVE    = 720,
  parameter int FCNT_WIDTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_enable,
  input  logic [PIXEL_WIDTH-1:0] s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   i_eol,
  input  logic                   i_eof,
  output logic [PIXEL_WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   o_busy,
  output logic [FCNT_WIDTH-1:0]  o_frame_cnt,
  input  logic                   i_err_clr,
  output logic                   o_err_line,
  output logic                   o_err_frame
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  // Stored beat layout: {tdata, eol, eof, sof}
  localparam int BW = PIXEL_WIDTH + 3;

  state_t               state, state_nxt;
  logic [BW-1:0]        out_q, out_nxt, skid_q, skid_nxt, in_beat;
  logic                 out_vld, out_vld_nxt, skid_vld, skid_vld_nxt;
  logic                 s_rdy, s_rdy_nxt, sof_pending;
  logic                 accept, out_fire, out_free;
  logic [FCNT_WIDTH-1:0] frame_cnt;

  assign accept   = s_axis_tvalid && s_rdy;
  assign out_fire = out_vld && m_axis_tready;
  assign out_free = !out_vld || m_axis_tready;
  assign in_beat  = {s_axis_tdata, i_eol, i_eof, sof_pending};

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  // Disable only lands on a frame boundary; an EOF accept while disabled ends the run.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_enable && sof_pending) state_nxt = S_ACTIVE;
      S_ACTIVE: if (!i_enable) state_nxt = (accept && i_eof) ? S_IDLE : S_DRAIN;
      S_DRAIN: begin
        if (i_enable)              state_nxt = S_ACTIVE;
        else if (accept && i_eof)  state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Skid is unloaded first; an accept never coincides with a full skid because ready is gated by it.
  always_comb begin
    out_vld_nxt  = out_vld;
    out_nxt      = out_q;
    skid_vld_nxt = skid_vld;
    skid_nxt     = skid_q;
    if (out_free) begin
      if (skid_vld) begin
        out_vld_nxt  = 1'b1;
        out_nxt      = skid_q;
        skid_vld_nxt = 1'b0;
      end else if (accept) begin
        out_vld_nxt = 1'b1;
        out_nxt     = in_beat;
      end else begin
        out_vld_nxt = 1'b0;
      end
    end else if (accept) begin
      skid_vld_nxt = 1'b1;
      skid_nxt     = in_beat;
    end
    s_rdy_nxt = !skid_vld_nxt && (state_nxt == S_ACTIVE || state_nxt == S_DRAIN);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      out_vld     <= 1'b0;
      out_q       <= '0;
      skid_vld    <= 1'b0;
      skid_q      <= '0;
      s_rdy       <= 1'b0;
      sof_pending <= 1'b1;
      frame_cnt   <= '0;
    end else begin
      out_vld  <= out_vld_nxt;
      out_q    <= out_nxt;
      skid_vld <= skid_vld_nxt;
      skid_q   <= skid_nxt;
      s_rdy    <= s_rdy_nxt;
      if (accept)              sof_pending <= i_eof;
      if (out_fire && out_q[1]) frame_cnt  <= frame_cnt + 1'b1;
    end
  end

  assign s_axis_tready = s_rdy;
  assign m_axis_tvalid = out_vld;
  assign m_axis_tdata  = out_q[BW-1:3];
  assign m_axis_tlast  = out_q[2];
  assign m_axis_tuser  = out_q[0];
  assign o_frame_cnt   = frame_cnt;
  assign o_busy        = (state != S_IDLE) || out_vld || skid_vld;

`ifdef VIDEO_FRAMER_GEOM_CHECK_EN
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          err_line, err_frame, line_bad, frame_bad;

  assign line_bad  = accept && (i_eol != (pos_x == X_LAST));
  assign frame_bad = accept && ((i_eof && pos_y != Y_LAST) ||
                                (i_eol && !i_eof && pos_y == Y_LAST));

  // Counters resync on the sideband so one bad line does not cascade; set beats clear.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pos_x     <= '0;
      pos_y     <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      if (accept) begin
        if (i_eol) begin
          pos_x <= '0;
          pos_y <= (i_eof || pos_y == Y_LAST) ? '0 : pos_y + 1'b1;
        end else begin
          pos_x <= (pos_x == X_LAST) ? '0 : pos_x + 1'b1;
        end
      end
      if (line_bad)       err_line <= 1'b1;
      else if (i_err_clr) err_line <= 1'b0;
      if (frame_bad)      err_frame <= 1'b1;
      else if (i_err_clr) err_frame <= 1'b0;
    end
  end

  assign o_err_line  = err_line;
  assign o_err_frame = err_frame;
`else
  localparam int unused_geom_dims = H_ACTIVE + V_ACTIVE;
  logic unused_err_clr;
  assign unused_err_clr = i_err_clr;
  assign o_err_line     = 1'b0;
  assign o_err_frame    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_video_out_framer.sv
// Self-checking bench for axis_video_out_framer: beat-queue model plus directed frame scenarios.
module tb_axis_video_out_framer;

  localparam int PW = 24;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int FW = 2;
`ifdef VIDEO_FRAMER_GEOM_CHECK_EN
  localparam logic GEOM = 1'b1;
`else
  localparam logic GEOM = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rstn = 1'b0;
  logic          i_enable = 1'b0;
  logic [PW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          i_eol = 1'b0;
  logic          i_eof = 1'b0;
  logic [PW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic          m_axis_tuser;
  logic          o_busy;
  logic [FW-1:0] o_frame_cnt;
  logic          i_err_clr = 1'b0;
  logic          o_err_line;
  logic          o_err_frame;

  axis_video_out_framer #(
    .PIXEL_WIDTH(PW), .H_ACTIVE(H), .V_ACTIVE(V), .FCNT_WIDTH(FW)
  ) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_enable(i_enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .i_eol(i_eol), .i_eof(i_eof),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .o_busy(o_busy), .o_frame_cnt(o_frame_cnt),
    .i_err_clr(i_err_clr), .o_err_line(o_err_line), .o_err_frame(o_err_frame)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [PW-1:0] data;
    logic          last;
    logic          user;
    logic          eof;
  } beat_t;

  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            tready_mode = 0;
  beat_t         exp_q[$];
  logic          model_sof = 1'b1;
  logic [FW-1:0] model_fcnt = '0;
  logic [PW-1:0] fired_data[$];
  logic          fired_user[$];
  logic          fired_last[$];
  int            fired_cyc[$];
  int            accept_cyc[$];
  int            wrap_exp[5] = '{1, 2, 3, 0, 1};

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sink ready pattern: always ready, or the repeating 1,0,0,1 stall pattern.
  always @(posedge i_clk) begin
    cyc++;
    #2;
    if (tready_mode == 1) m_axis_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
    else                  m_axis_tready = 1'b1;
  end

  // Per-cycle comparison against the expected beat queue and frame count.
  logic          prev_stall = 1'b0;
  logic [PW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic          prev_user = 1'b0;
  always @(negedge i_clk) begin
    beat_t e;
    if (!i_rstn) begin
      prev_stall = 1'b0;
    end else begin
      checkOutput("frame_cnt", 32'(o_frame_cnt), 32'(model_fcnt));
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("stall_data", 32'(m_axis_tdata), 32'(prev_data));
        checkOutput("stall_last", 32'(m_axis_tlast), 32'(prev_last));
        checkOutput("stall_user", 32'(m_axis_tuser), 32'(prev_user));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_beat: got beat 0x%0h, expected no beat", m_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          if (m_axis_tdata !== e.data || m_axis_tlast !== e.last || m_axis_tuser !== e.user) begin
            errors++;
            $display("[TB] FAIL beat: got data=0x%0h last=%0b user=%0b, expected data=0x%0h last=%0b user=%0b",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.data, e.last, e.user);
          end
          if (e.eof) model_fcnt = model_fcnt + 1'b1;
        end
        fired_data.push_back(m_axis_tdata);
        fired_user.push_back(m_axis_tuser);
        fired_last.push_back(m_axis_tlast);
        fired_cyc.push_back(cyc);
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_last  = m_axis_tlast;
      prev_user  = m_axis_tuser;
    end
  end

  task automatic clearLogs();
    fired_data.delete();
    fired_user.delete();
    fired_last.delete();
    fired_cyc.delete();
    accept_cyc.delete();
  endtask

  // Called just after a falling edge; returns one falling edge after the accept.
  task automatic sendBeat(input logic [PW-1:0] d, input logic eol, input logic eof);
    int    waited = 0;
    beat_t b;
    s_axis_tdata  = d;
    i_eol         = eol;
    i_eof         = eof;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && waited < 300) begin
      @(negedge i_clk);
      waited++;
    end
    if (!s_axis_tready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: s_axis_tready=0 for beat 0x%0h, expected 1", d);
    end else begin
      b.data = d;
      b.last = eol;
      b.user = model_sof;
      b.eof  = eof;
      exp_q.push_back(b);
      model_sof = eof;
      accept_cyc.push_back(cyc);
    end
    @(negedge i_clk);
  endtask

  function automatic logic [PW-1:0] pix(input int fid, input int y, input int x);
    return {8'(fid), 8'(y), 8'(x)};
  endfunction

  task automatic applyStimulus(input int fid, input int drop_at);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        if (y * H + x == drop_at) i_enable = 1'b0;
        sendBeat(pix(fid, y, x), x == H - 1, (x == H - 1) && (y == V - 1));
      end
    end
    s_axis_tvalid = 1'b0;
  endtask

  task automatic waitDrain(input logic want_idle);
    int n = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid || (want_idle && o_busy)) && n < 500) begin
      @(negedge i_clk);
      n++;
    end
    checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    if (want_idle) checkOutput("busy_idle", 32'(o_busy), 32'd0);
  endtask

  task automatic doReset();
    @(posedge i_clk);
    #3;
    i_rstn        = 1'b0;
    s_axis_tvalid = 1'b0;
    exp_q.delete();
    model_sof  = 1'b1;
    model_fcnt = '0;
    #1;
    checkOutput("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_m_data", 32'(m_axis_tdata), 32'd0);
    checkOutput("rst_m_last", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_m_user", 32'(m_axis_tuser), 32'd0);
    checkOutput("rst_s_ready", 32'(s_axis_tready), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_fcnt", 32'(o_frame_cnt), 32'd0);
    checkOutput("rst_err", 32'({o_err_line, o_err_frame}), 32'd0);
    repeat (2) @(posedge i_clk);
    #3;
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic checkFrameShape(input string tag, input int base, input int fid);
    for (int i = 0; i < H * V; i++) begin
      checkOutput({tag, "_data"}, 32'(fired_data[base + i]), 32'(pix(fid, i / H, i % H)));
      checkOutput({tag, "_user"}, 32'(fired_user[base + i]), 32'(i == 0));
      checkOutput({tag, "_last"}, 32'(fired_last[base + i]), 32'((i % H) == H - 1));
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Nominal 4x2 frame, continuous ready
    doReset();
    i_enable = 1'b1;
    clearLogs();
    applyStimulus(0, -1);
    waitDrain(1'b0);
    checkOutput("t1_count", 32'(fired_data.size()), 32'd8);
    if (fired_data.size() == 8) begin
      checkFrameShape("t1", 0, 0);
      checkOutput("t1_latency", 32'(fired_cyc[0] - accept_cyc[0]), 32'd1);
      checkOutput("t1_throughput", 32'(fired_cyc[7] - fired_cyc[0]), 32'd7);
    end
    checkOutput("t1_fcnt", 32'(o_frame_cnt), 32'd1);

    // Same frame shape with a stalling sink
    tready_mode = 1;
    clearLogs();
    applyStimulus(1, -1);
    waitDrain(1'b0);
    checkOutput("t2_count", 32'(fired_data.size()), 32'd8);
    if (fired_data.size() == 8) checkFrameShape("t2", 0, 1);
    checkOutput("t2_fcnt", 32'(o_frame_cnt), 32'd2);
    tready_mode = 0;

    // Disable mid-frame: frame completes, then no more accepts until re-enable
    doReset();
    i_enable = 1'b1;
    clearLogs();
    applyStimulus(0, -1);
    applyStimulus(1, 2);
    s_axis_tdata  = pix(2, 0, 0);
    i_eol         = 1'b0;
    i_eof         = 1'b0;
    s_axis_tvalid = 1'b1;
    repeat (6) begin
      @(negedge i_clk);
      checkOutput("t3_idle_tready", 32'(s_axis_tready), 32'd0);
    end
    waitDrain(1'b1);
    checkOutput("t3_count", 32'(fired_data.size()), 32'd16);
    if (fired_data.size() == 16) checkFrameShape("t3_f1", 8, 1);
    i_enable = 1'b1;
    applyStimulus(2, -1);
    waitDrain(1'b0);
    checkOutput("t3_count2", 32'(fired_data.size()), 32'd24);
    if (fired_data.size() == 24) checkFrameShape("t3_f2", 16, 2);
    checkOutput("t3_fcnt", 32'(o_frame_cnt), 32'd3);

    // Reset in the middle of a frame
    doReset();
    i_enable = 1'b1;
    for (int i = 0; i < 5; i++) sendBeat(pix(3, i / H, i % H), (i % H) == H - 1, 1'b0);
    doReset();
    checkOutput("t4_fcnt0", 32'(o_frame_cnt), 32'd0);
    clearLogs();
    applyStimulus(4, -1);
    waitDrain(1'b0);
    checkOutput("t4_count", 32'(fired_data.size()), 32'd8);
    if (fired_data.size() == 8) begin
      checkOutput("t4_first_user", 32'(fired_user[0]), 32'd1);
      checkOutput("t4_first_data", 32'(fired_data[0]), 32'h040000);
    end
    checkOutput("t4_fcnt1", 32'(o_frame_cnt), 32'd1);

    // Geometry errors: EOF at y=0, then EOL at x=2
    doReset();
    i_enable = 1'b1;
    for (int x = 0; x < H; x++) sendBeat(pix(5, 0, x), x == H - 1, x == H - 1);
    s_axis_tvalid = 1'b0;
    waitDrain(1'b0);
    checkOutput("t5_frame_err", 32'(o_err_frame), 32'(GEOM));
    checkOutput("t5_line_ok", 32'(o_err_line), 32'd0);
    for (int x = 0; x < 3; x++) sendBeat(pix(6, 0, x), x == 2, 1'b0);
    for (int x = 0; x < H; x++) sendBeat(pix(6, 1, x), x == H - 1, x == H - 1);
    s_axis_tvalid = 1'b0;
    waitDrain(1'b0);
    repeat (5) @(negedge i_clk);
    checkOutput("t5_line_err", 32'(o_err_line), 32'(GEOM));
    checkOutput("t5_frame_hold", 32'(o_err_frame), 32'(GEOM));
    i_err_clr = 1'b1;
    @(negedge i_clk);
    i_err_clr = 1'b0;
    checkOutput("t5_clr_line", 32'(o_err_line), 32'd0);
    checkOutput("t5_clr_frame", 32'(o_err_frame), 32'd0);

    // Frame counter wrap with a 2-bit counter
    doReset();
    i_enable = 1'b1;
    for (int f = 0; f < 5; f++) begin
      applyStimulus(f, -1);
      waitDrain(1'b0);
      checkOutput("t6_fcnt_wrap", 32'(o_frame_cnt), 32'(wrap_exp[f]));
    end
    checkOutput("t6_no_err", 32'({o_err_line, o_err_frame}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
